// File: rtl/dspl_arbiter.sv
// Two-client round-robin arbiter with minimum dwell time for the eight-digit display driver.
// The owner's 48-bit frame is forwarded to d1..d8 one edge after the grant is taken.
module dspl_arbiter #(
    parameter logic [31:0] DWELL_TICKS = 32'd100_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_a,
    input  logic [47:0] frame_a,
    input  logic        req_b,
    input  logic [47:0] frame_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        busy,
    output logic [5:0]  d1,
    output logic [5:0]  d2,
    output logic [5:0]  d3,
    output logic [5:0]  d4,
    output logic [5:0]  d5,
    output logic [5:0]  d6,
    output logic [5:0]  d7,
    output logic [5:0]  d8
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [31:0] DWELL_LAST = DWELL_TICKS - 32'd1;

    state_t      state_q, state_d;
    logic        pref_q, pref_d;
    logic [31:0] dwell_q, dwell_d;
    logic [47:0] frame_q, frame_d;
    logic        gnt_a_q, gnt_b_q;

    always_comb begin
        state_d = state_q;
        pref_d  = pref_q;
        dwell_d = 32'd0;
        frame_d = 48'd0;

        case (state_q)
            IDLE: begin
                if (req_a && !(req_b && pref_q)) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                frame_d = frame_a;
                if (!req_a) begin
                    state_d = req_b ? OWN_B : IDLE;
                end else if (req_b && (dwell_q == DWELL_LAST)) begin
                    state_d = OWN_B;
                end
            end
            OWN_B: begin
                frame_d = frame_b;
                if (!req_b) begin
                    state_d = req_a ? OWN_A : IDLE;
                end else if (req_a && (dwell_q == DWELL_LAST)) begin
                    state_d = OWN_A;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pointer flips away from whichever client just took ownership.
        if (state_d == OWN_A && state_q != OWN_A) begin
            pref_d = 1'b1;
        end else if (state_d == OWN_B && state_q != OWN_B) begin
            pref_d = 1'b0;
        end

        // Dwell only runs while ownership is unchanged; it saturates so an
        // uncontested owner can sit here forever.
        if (state_d == state_q && state_q != IDLE) begin
            dwell_d = (dwell_q == DWELL_LAST) ? dwell_q : dwell_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            pref_q  <= 1'b0;
            dwell_q <= 32'd0;
            frame_q <= 48'd0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pref_q  <= pref_d;
            dwell_q <= dwell_d;
            frame_q <= frame_d;
            gnt_a_q <= (state_d == OWN_A);
            gnt_b_q <= (state_d == OWN_B);
        end
    end

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign busy  = gnt_a_q | gnt_b_q;

    assign d1 = frame_q[5:0];
    assign d2 = frame_q[11:6];
    assign d3 = frame_q[17:12];
    assign d4 = frame_q[23:18];
    assign d5 = frame_q[29:24];
    assign d6 = frame_q[35:30];
    assign d7 = frame_q[41:36];
    assign d8 = frame_q[47:42];

endmodule

// File: tb/tb_dspl_arbiter.sv
// Bench for dspl_arbiter with DWELL_TICKS=4: a behavioural owner/tenure model predicts
// {gnt_a, gnt_b, busy, d8..d1} for every edge, queued and compared on the following negedge.
module tb_dspl_arbiter;

    localparam int DW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [47:0] frame_a = 48'd0;
    logic [47:0] frame_b = 48'd0;
    logic        gnt_a, gnt_b, busy;
    logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;

    dspl_arbiter #(.DWELL_TICKS(32'd4)) dut (
        .clock   (clock),
        .reset   (reset),
        .req_a   (req_a),
        .frame_a (frame_a),
        .req_b   (req_b),
        .frame_b (frame_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .busy    (busy),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .d4      (d4),
        .d5      (d5),
        .d6      (d6),
        .d7      (d7),
        .d8      (d8)
    );

    always #5 clock = ~clock;

    // Scoreboard state
    logic [50:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model: owner 0=none, 1=A, 2=B; tenure counts edges since entry.
    int          m_owner = 0;
    logic        m_pref = 1'b0;
    int          m_tenure = 0;
    logic [47:0] m_d = 48'd0;

    task automatic check(input string tag, input logic [50:0] got, input logic [50:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic ra, input logic rb,
                              input logic [47:0] fa, input logic [47:0] fb);
        int nxt;
        if (!rst) begin
            m_owner  = 0;
            m_pref   = 1'b0;
            m_tenure = 0;
            m_d      = 48'd0;
        end else begin
            m_d = (m_owner == 1) ? fa : (m_owner == 2) ? fb : 48'd0;
            nxt = m_owner;
            if (m_owner == 0) begin
                if (ra && rb)  nxt = m_pref ? 2 : 1;
                else if (ra)   nxt = 1;
                else if (rb)   nxt = 2;
            end else if (m_owner == 1) begin
                if (!ra)                           nxt = rb ? 2 : 0;
                else if (rb && m_tenure >= DW - 1) nxt = 2;
            end else begin
                if (!rb)                           nxt = ra ? 1 : 0;
                else if (ra && m_tenure >= DW - 1) nxt = 1;
            end
            if (nxt != m_owner) begin
                m_tenure = 0;
                if (nxt == 1) m_pref = 1'b1;
                if (nxt == 2) m_pref = 1'b0;
            end else if (m_owner != 0) begin
                m_tenure++;
            end
            m_owner = nxt;
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then compare them.
    task automatic tick(input logic rst, input logic ra, input logic rb,
                        input logic [47:0] fa, input logic [47:0] fb);
        logic [50:0] exp;
        logic [50:0] got;
        reset   = rst;
        req_a   = ra;
        req_b   = rb;
        frame_a = fa;
        frame_b = fb;
        model_edge(rst, ra, rb, fa, fb);
        exp_q.push_back({m_owner == 1, m_owner == 2, m_owner != 0, m_d});
        @(posedge clock);
        @(negedge clock);
        got = {gnt_a, gnt_b, busy, d8, d7, d6, d5, d4, d3, d2, d1};
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty got=%h", got);
        end else begin
            exp = exp_q.pop_front();
            check("sb", got, exp);
            if (gnt_a && gnt_b) check("excl", 51'd1, 51'd0);
        end
    endtask

    logic [11:0] pat_b;
    logic [47:0] fa_r, fb_r;

    initial begin
        // 1. Reset dominates requests; first edge after release grants A.
        tick(1'b0, 1'b1, 1'b1, 48'h1, 48'h2);
        tick(1'b0, 1'b1, 1'b1, 48'h1, 48'h2);
        check("rst_out", {gnt_a, gnt_b, busy, d1, d8}, 51'd0);
        tick(1'b1, 1'b1, 1'b0, 48'h1, 48'h2);
        check("rst_first_a", {50'd0, gnt_a}, 51'd1);

        // 2. Single client, then live frame update.
        tick(1'b0, 1'b0, 1'b0, 48'h0, 48'h0);
        tick(1'b1, 1'b1, 1'b0, 48'h23, 48'h15);
        check("single_gnt", {50'd0, gnt_a}, 51'd1);
        tick(1'b1, 1'b1, 1'b0, 48'h23, 48'h15);
        check("single_d1", {45'd0, d1}, 51'h23);
        tick(1'b1, 1'b1, 1'b0, 48'h3F, 48'h15);
        check("live_d1", {45'd0, d1}, 51'h3F);

        // 3. Contention from reset release: A x4, B x4, A x4.
        tick(1'b0, 1'b1, 1'b1, 48'hAAAA_AAAA_AAAA, 48'h5555_5555_5555);
        pat_b = 12'b0000_1111_0000;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1, 1'b1, 48'hAAAA_AAAA_AAAA, 48'h5555_5555_5555);
            check("rr_pat", {50'd0, gnt_b}, {50'd0, pat_b[11-i]});
        end

        // 4. Late contender arrives while dwell=1.
        tick(1'b0, 1'b0, 1'b0, 48'h0, 48'h0);
        tick(1'b1, 1'b1, 1'b0, 48'h0123_4567_89AB, 48'hFEDC_BA98_7654);
        tick(1'b1, 1'b1, 1'b0, 48'h0123_4567_89AB, 48'hFEDC_BA98_7654);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 1'b1, 48'h0123_4567_89AB, 48'hFEDC_BA98_7654);
            check("late_busy", {50'd0, busy}, 51'd1);
        end

        // 5. Release to idle, B alone, then a tie goes to A.
        tick(1'b1, 1'b0, 1'b0, 48'h0, 48'h0);
        tick(1'b1, 1'b1, 1'b0, 48'h11, 48'h22);
        tick(1'b1, 1'b1, 1'b0, 48'h11, 48'h22);
        tick(1'b1, 1'b0, 1'b0, 48'h11, 48'h22);
        check("rel_busy", {50'd0, busy}, 51'd0);
        tick(1'b1, 1'b0, 1'b0, 48'h11, 48'h22);
        check("rel_blank", {3'd0, d8, d7, d6, d5, d4, d3, d2, d1}, 51'd0);
        tick(1'b1, 1'b0, 1'b1, 48'h11, 48'h22);
        tick(1'b1, 1'b0, 1'b1, 48'h11, 48'h22);
        tick(1'b1, 1'b0, 1'b0, 48'h11, 48'h22);
        tick(1'b1, 1'b1, 1'b1, 48'h11, 48'h22);
        check("tie_a", {49'd0, gnt_a, gnt_b}, 51'b10);

        // 6. Reset in the middle of B's ownership.
        tick(1'b1, 1'b0, 1'b1, 48'h0, 48'h3F3F);
        tick(1'b1, 1'b0, 1'b1, 48'h0, 48'h3F3F);
        tick(1'b0, 1'b0, 1'b1, 48'h0, 48'h3F3F);
        check("mid_rst", {gnt_a, gnt_b, busy, d8, d7, d6, d5, d4, d3, d2, d1}, 51'd0);
        tick(1'b1, 1'b1, 1'b1, 48'h7, 48'h3F3F);
        check("mid_rst_tie", {49'd0, gnt_a, gnt_b}, 51'b10);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            fa_r = {$urandom(), $urandom_range(0, 65535)};
            fb_r = {$urandom(), $urandom_range(0, 65535)};
            tick($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, fa_r, fb_r);
        end

        if (exp_q.size() != 0) check("sb_left", 51'(exp_q.size()), 51'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dspl_arbiter.md
# dspl_arbiter

Two-client arbiter for the eight-digit display driver. It decides which of two frame producers owns the display, for example a running counter and a status/message source. It forwards the owner's 48-bit frame to the driver's d1..d8 inputs and enforces round-robin fairness with a minimum dwell time. It sits between the application logic and the display driver, in the same clock domain as the driver's input clock.

## Interface
- DWELL_TICKS, default 100000000: minimum ownership time in clock cycles before a contested switch (1 s at 100 MHz). Legal range 1..2^32-1.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset. Low at a rising edge resets the block.
- req_a  in  1  client A requests the display. Level-sensitive; held high while the client wants ownership.
- frame_a  in  48  client A frame. frame_a[6k+5:6k] maps to digit d(k+1), k=0..7. Each field is {enable, hex[3:0], dp}.
- req_b  in  1  client B request, same rules as req_a.
- frame_b  in  48  client B frame, same packing as frame_a.
- gnt_a  out  1  client A currently owns the display.
- gnt_b  out  1  client B currently owns the display.
- busy  out  1  high when either grant is high.
- d1..d8  out  6 each  registered digit fields to the display driver.

## Operation
- FSM states: IDLE, OWN_A, OWN_B. gnt_a=1 exactly in OWN_A, gnt_b=1 exactly in OWN_B, and busy = gnt_a|gnt_b. The two grants are never high together.
- Round-robin pointer `pref` (1 bit, 0 = A preferred):
  - On entry to OWN_A, pref becomes 1.
  - On entry to OWN_B, pref becomes 0.
- IDLE transitions:
  - Only req_a → OWN_A.
  - Only req_b → OWN_B.
  - Both requests → the pref client.
  - Neither → stay in IDLE.
- OWN_x transitions (y is the other client):
  - req_x=0 → OWN_y if req_y=1, else IDLE.
  - req_x=1, req_y=1 and dwell == DWELL_TICKS-1 → OWN_y.
  - Otherwise stay in OWN_x.
- Dwell counter (32-bit):
  - Cleared to 0 on every state change and in IDLE.
  - Increments each cycle in an OWN state and saturates at DWELL_TICKS-1.
  - With no contender, the owner keeps the display indefinitely.
- A direct switch moves the grant edge-to-edge. gnt_x falls and gnt_y rises on the same edge, with no gap cycle.
- Data path: each edge loads d1..d8 from the frame of the client granted in the current state, before the transition takes effect. In IDLE, all d fields load 6'b0, which blanks every digit because the enable bit is 0.
- Frames are followed live. A change in the owner's frame appears on d one edge later. The non-owner's frame is ignored.

## Timing
- Reset (reset=0 at an edge):
  - state=IDLE, pref=0, dwell=0.
  - gnt_a=gnt_b=busy=0, d1..d8=6'b0.
  - This applies from any state, including mid-ownership. The reset takes priority over all requests sampled at the same edge.
- Request to grant: req sampled high at edge n in IDLE → grant high after edge n.
- Grant to data: the grant first holds after edge n, and d shows that client's frame after edge n+1. d therefore lags the grant by exactly one cycle.
- Release: owner req sampled low at edge k → grant low after edge k. After edge k+1, d is blanked, or shows the new owner's frame on a direct switch.
- Contested switch: the owner holds the grant for exactly DWELL_TICKS cycles after entry, provided the contender is already requesting.
  - If the contender arrives later, the switch happens at the first edge where dwell == DWELL_TICKS-1 and req_y=1.
  - With DWELL_TICKS=1, contested ownership alternates every cycle.
- Simultaneous release and contest (req_x=0, req_y=1): switch to y regardless of dwell.
- Requests are not latched. A request dropped before it is granted is forgotten.

## Test plan
Benches use DWELL_TICKS=4.
1. Reset: hold reset=0 for 2 edges with req_a=req_b=1 → gnt_a=gnt_b=busy=0 and d1..d8=0. After reset=1, the first edge gives gnt_a=1 (pref=0).
2. Single client: req_a=1 with frame_a=48'h0000_0000_0023 → gnt_a=1 after the first edge and d1=6'h23 (others 0) after the second. Change frame_a[5:0]=6'h3F → d1=6'h3F one edge later.
3. Contention: req_a=req_b=1 held from reset release → grants alternate A,A,A,A,B,B,B,B,A,…, and d lags each grant by one cycle.
4. Late contender: A owns; req_b rises when dwell=1 → switch to OWN_B exactly at the edge where dwell=3, with no cycle where both grants are low.
5. Release: A owns, req_b=0, req_a drops → gnt_a=0 and busy=0 after one edge, d1..d8=0 after the next. req_b then rises → B is granted, then A on a later tie (pref restored).
6. Reset mid-operation: in OWN_B, assert reset=0 for 1 edge with frame_b nonzero → all outputs are 0 after that edge. A tie after release grants A.
